// File: rtl/regfile_write_arbiter.sv
// Two-requester write arbiter for a single register-file write port.
// Each requester owns a one-entry skid buffer. A round-robin pointer picks
// between two full buffers. The granted entry is registered onto the write
// port on the next edge. Writes addressed to register 0 are consumed
// silently and counted in drop_count.
module regfile_write_arbiter #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              rf_write,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_data,
    input  logic [ADDR_W-1:0] query_addr,
    output logic              pending,
    output logic [7:0]        drop_count
);

    typedef enum logic {
        PTR_REQ0 = 1'b0,
        PTR_REQ1 = 1'b1
    } ptr_e;

    ptr_e              r_ptr;
    logic              r_full0;
    logic              r_full1;
    logic [ADDR_W-1:0] r_addr0;
    logic [ADDR_W-1:0] r_addr1;
    logic [DATA_W-1:0] r_data0;
    logic [DATA_W-1:0] r_data1;
    logic              r_rf_write;
    logic [ADDR_W-1:0] r_rf_addr;
    logic [DATA_W-1:0] r_rf_data;
    logic [7:0]        r_drop_count;

    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_acc0;
    logic              w_acc1;
    logic [ADDR_W-1:0] w_gnt_addr;
    logic [DATA_W-1:0] w_gnt_data;

    // Grant selection, ready generation and pending lookup.
    // A buffer being granted this cycle can be refilled in the same cycle.
    always_comb begin
        w_gnt0     = r_full0 && (!r_full1 || (r_ptr == PTR_REQ0));
        w_gnt1     = r_full1 && !w_gnt0;
        req0_ready = !r_full0 || w_gnt0;
        req1_ready = !r_full1 || w_gnt1;
        w_acc0     = req0_valid && req0_ready;
        w_acc1     = req1_valid && req1_ready;
        w_gnt_addr = w_gnt0 ? r_addr0 : r_addr1;
        w_gnt_data = w_gnt0 ? r_data0 : r_data1;
        pending    = (query_addr != '0) &&
                     ((r_full0 && (r_addr0 == query_addr)) ||
                      (r_full1 && (r_addr1 == query_addr)) ||
                      (r_rf_write && (r_rf_addr == query_addr)));
    end

    // Requester 0 buffer: a load wins over the release by a grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_full0 <= 1'b0;
            r_addr0 <= '0;
            r_data0 <= '0;
        end else if (w_acc0) begin
            r_full0 <= 1'b1;
            r_addr0 <= req0_addr;
            r_data0 <= req0_data;
        end else if (w_gnt0) begin
            r_full0 <= 1'b0;
        end
    end

    // Requester 1 buffer: a load wins over the release by a grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_full1 <= 1'b0;
            r_addr1 <= '0;
            r_data1 <= '0;
        end else if (w_acc1) begin
            r_full1 <= 1'b1;
            r_addr1 <= req1_addr;
            r_data1 <= req1_data;
        end else if (w_gnt1) begin
            r_full1 <= 1'b0;
        end
    end

    // Register the granted write, drop register-0 writes, and rotate priority.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr        <= PTR_REQ0;
            r_rf_write   <= 1'b0;
            r_rf_addr    <= '0;
            r_rf_data    <= '0;
            r_drop_count <= '0;
        end else begin
            r_rf_write <= 1'b0;
            if (w_gnt0 || w_gnt1) begin
                r_ptr <= w_gnt0 ? PTR_REQ1 : PTR_REQ0;
                if (w_gnt_addr == '0) begin
                    if (r_drop_count != '1) begin
                        r_drop_count <= r_drop_count + 8'd1;
                    end
                end else begin
                    r_rf_write <= 1'b1;
                    r_rf_addr  <= w_gnt_addr;
                    r_rf_data  <= w_gnt_data;
                end
            end
        end
    end

    assign rf_write   = r_rf_write;
    assign rf_addr    = r_rf_addr;
    assign rf_data    = r_rf_data;
    assign drop_count = r_drop_count;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter. A queue-based model of the two requesters
// and of the register file predicts every output each cycle.
module tb_regfile_write_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0_valid, req1_valid;
    logic [AW-1:0] req0_addr, req1_addr;
    logic [DW-1:0] req0_data, req1_data;
    logic          req0_ready, req1_ready;
    logic          rf_write;
    logic [AW-1:0] rf_addr;
    logic [DW-1:0] rf_data;
    logic [AW-1:0] query_addr;
    logic          pending;
    logic [7:0]    drop_count;

    regfile_write_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
        .rf_write(rf_write), .rf_addr(rf_addr), .rf_data(rf_data),
        .query_addr(query_addr), .pending(pending), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    // Register file as seen through the DUT write port.
    logic [DW-1:0] tb_rf [32];
    always @(posedge clk) if (!reset && rf_write) tb_rf[rf_addr] <= rf_data;

    typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;

    // Reference model: offers waiting per requester, favoured requester,
    // the write currently on the port, drop count, and register contents.
    wr_t           q0[$], q1[$];
    int            m_pref;
    bit            m_rfw;
    logic [AW-1:0] m_rfa;
    logic [DW-1:0] m_rfd;
    int            m_drop;
    logic [DW-1:0] m_rf [32];

    int n_chk = 0, n_pass = 0;
    bit obs_w, obs_r0, obs_r1, obs_p;
    logic [7:0] obs_drop;
    bit acc0, acc1;
    logic [AW-1:0] alog[$];
    logic [DW-1:0] wlog[$];
    bit prev_both_low;
    int both_low_twice;

    task automatic model_reset();
        q0.delete(); q1.delete();
        m_pref = 0; m_rfw = 0; m_rfa = '0; m_rfd = '0; m_drop = 0;
    endtask

    // One clock cycle: drive inputs, predict, sample at negedge, advance model at posedge.
    task automatic step(input bit v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                        input bit v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                        input logic [AW-1:0] qa);
        int ch;
        bit e_r0, e_r1, e_p;
        wr_t w;
        req0_valid = v0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_data = d1;
        query_addr = qa;
        ch = -1;
        if (q0.size() != 0 && (q1.size() == 0 || m_pref == 0)) ch = 0;
        else if (q1.size() != 0) ch = 1;
        e_r0 = (q0.size() == 0) || (ch == 0);
        e_r1 = (q1.size() == 0) || (ch == 1);
        e_p = 0;
        if (qa != 0) begin
            if (q0.size() != 0 && q0[0].addr == qa) e_p = 1;
            if (q1.size() != 0 && q1[0].addr == qa) e_p = 1;
            if (m_rfw && m_rfa == qa) e_p = 1;
        end
        @(negedge clk);
        obs_w = rf_write; obs_r0 = req0_ready; obs_r1 = req1_ready; obs_p = pending; obs_drop = drop_count;
        n_chk++; if (req0_ready !== e_r0) $display("FAIL req0_ready got %0b exp %0b t=%0t", req0_ready, e_r0, $time); else n_pass++;
        n_chk++; if (req1_ready !== e_r1) $display("FAIL req1_ready got %0b exp %0b t=%0t", req1_ready, e_r1, $time); else n_pass++;
        n_chk++; if (rf_write !== m_rfw) $display("FAIL rf_write got %0b exp %0b t=%0t", rf_write, m_rfw, $time); else n_pass++;
        n_chk++; if (rf_addr !== m_rfa) $display("FAIL rf_addr got %0d exp %0d t=%0t", rf_addr, m_rfa, $time); else n_pass++;
        n_chk++; if (rf_data !== m_rfd) $display("FAIL rf_data got %0h exp %0h t=%0t", rf_data, m_rfd, $time); else n_pass++;
        n_chk++; if (pending !== e_p) $display("FAIL pending got %0b exp %0b q=%0d t=%0t", pending, e_p, qa, $time); else n_pass++;
        n_chk++; if (drop_count !== 8'(m_drop)) $display("FAIL drop_count got %0d exp %0d t=%0t", drop_count, m_drop, $time); else n_pass++;
        if (rf_write) begin alog.push_back(rf_addr); wlog.push_back(rf_data); end
        if (!req0_ready && !req1_ready) begin
            if (prev_both_low) both_low_twice++;
            prev_both_low = 1;
        end else prev_both_low = 0;
        @(posedge clk);
        if (m_rfw) m_rf[m_rfa] = m_rfd;
        m_rfw = 0;
        if (ch == 0) w = q0.pop_front();
        else if (ch == 1) w = q1.pop_front();
        if (ch >= 0) begin
            if (w.addr == 0) begin
                if (m_drop < 255) m_drop++;
            end else begin
                m_rfw = 1; m_rfa = w.addr; m_rfd = w.data;
            end
            m_pref = (ch == 0) ? 1 : 0;
        end
        acc0 = v0 && e_r0;
        acc1 = v1 && e_r1;
        if (acc0) begin w.addr = a0; w.data = d0; q0.push_back(w); end
        if (acc1) begin w.addr = a1; w.data = d1; q1.push_back(w); end
        #1;
    endtask

    task automatic idle(input int n, input logic [AW-1:0] qa);
        for (int i = 0; i < n; i++) step(0, '0, '0, 0, '0, '0, qa);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        req0_valid = 0; req1_valid = 0;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        prev_both_low = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req0_valid = 0; req1_valid = 0; query_addr = 5'd3;
        #1;
        n_chk++; if (rf_write !== 1'b0) $display("FAIL reset_rf_write got %0b exp 0", rf_write); else n_pass++;
        n_chk++; if (rf_addr !== '0) $display("FAIL reset_rf_addr got %0d exp 0", rf_addr); else n_pass++;
        n_chk++; if (rf_data !== '0) $display("FAIL reset_rf_data got %0h exp 0", rf_data); else n_pass++;
        n_chk++; if (drop_count !== 8'd0) $display("FAIL reset_drop got %0d exp 0", drop_count); else n_pass++;
        n_chk++; if (req0_ready !== 1'b1 || req1_ready !== 1'b1) $display("FAIL reset_ready got %0b%0b exp 11", req0_ready, req1_ready); else n_pass++;
        n_chk++; if (pending !== 1'b0) $display("FAIL reset_pending got %0b exp 0", pending); else n_pass++;
        apply_reset();
    endtask

    task automatic test_single();
        apply_reset();
        step(1, 5'd5, 32'hDEADBEEF, 0, '0, '0, '0);
        step(0, '0, '0, 0, '0, '0, '0);
        n_chk++; if (obs_w !== 1'b0) $display("FAIL single_early got %0b exp 0", obs_w); else n_pass++;
        step(0, '0, '0, 0, '0, '0, '0);
        n_chk++; if (obs_w !== 1'b1 || rf_addr !== 5'd5 || rf_data !== 32'hDEADBEEF)
            $display("FAIL single_write got w=%0b a=%0d d=%0h exp w=1 a=5 d=deadbeef", obs_w, rf_addr, rf_data); else n_pass++;
        step(0, '0, '0, 0, '0, '0, '0);
        n_chk++; if (obs_w !== 1'b0) $display("FAIL single_once got %0b exp 0", obs_w); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] a0, a1;
        logic [AW-1:0] expv [6];
        expv = '{5'd1, 5'd17, 5'd2, 5'd18, 5'd3, 5'd19};
        apply_reset();
        alog.delete(); both_low_twice = 0;
        a0 = 5'd1; a1 = 5'd17;
        for (int i = 0; i < 10; i++) begin
            step(1, a0, $urandom, 1, a1, $urandom, '0);
            if (acc0) a0++;
            if (acc1) a1++;
        end
        n_chk++; if (alog.size() < 6) $display("FAIL stream_len got %0d exp >=6", alog.size()); else n_pass++;
        for (int i = 0; i < 6; i++) begin
            if (i < alog.size()) begin
                n_chk++; if (alog[i] !== expv[i]) $display("FAIL stream_addr[%0d] got %0d exp %0d", i, alog[i], expv[i]); else n_pass++;
            end
        end
        n_chk++; if (both_low_twice != 0) $display("FAIL stream_readies got %0d exp 0", both_low_twice); else n_pass++;
        idle(3, '0);
    endtask

    task automatic test_drop();
        int n_w;
        apply_reset();
        n_w = alog.size();
        step(0, '0, '0, 1, '0, 32'h1, '0);
        n_chk++; if (obs_drop !== 8'd0) $display("FAIL drop_initial got %0d exp 0", obs_drop); else n_pass++;
        for (int i = 0; i < 262; i++) begin
            step(0, '0, '0, 1, '0, $urandom, '0);
            if (i == 1) begin
                n_chk++; if (obs_drop !== 8'd1) $display("FAIL drop_first got %0d exp 1", obs_drop); else n_pass++;
            end
            if (i == 100) begin
                n_chk++; if (obs_r1 !== 1'b1) $display("FAIL drop_ready got %0b exp 1", obs_r1); else n_pass++;
            end
        end
        n_chk++; if (obs_drop !== 8'd255) $display("FAIL drop_saturate got %0d exp 255", obs_drop); else n_pass++;
        n_chk++; if (alog.size() != n_w) $display("FAIL drop_no_write got %0d exp %0d", alog.size() - n_w, 0); else n_pass++;
        idle(2, '0);
    endtask

    task automatic test_pending();
        apply_reset();
        step(1, 5'd2, 32'h22, 0, '0, '0, '0);
        step(0, '0, '0, 0, '0, '0, '0);
        step(1, 5'd9, 32'h99, 1, 5'd4, 32'h44, '0);
        step(0, '0, '0, 0, '0, '0, 5'd9);
        n_chk++; if (obs_p !== 1'b1) $display("FAIL pend_buffered got %0b exp 1", obs_p); else n_pass++;
        step(0, '0, '0, 0, '0, '0, 5'd0);
        n_chk++; if (obs_p !== 1'b0) $display("FAIL pend_zero got %0b exp 0", obs_p); else n_pass++;
        step(0, '0, '0, 0, '0, '0, 5'd9);
        n_chk++; if (obs_p !== 1'b1) $display("FAIL pend_on_port got %0b exp 1", obs_p); else n_pass++;
        step(0, '0, '0, 0, '0, '0, 5'd9);
        n_chk++; if (obs_p !== 1'b0) $display("FAIL pend_committed got %0b exp 0", obs_p); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int n_w;
        apply_reset();
        step(1, 5'd10, 32'hA0, 1, 5'd11, 32'hB0, '0);
        step(1, 5'd12, 32'hA1, 1, 5'd13, 32'hB1, '0);
        req0_valid = 0; req1_valid = 0; query_addr = 5'd11;
        #2 reset = 1'b1;
        #1;
        n_chk++; if (rf_write !== 1'b0) $display("FAIL midrst_rf_write got %0b exp 0", rf_write); else n_pass++;
        n_chk++; if (req0_ready !== 1'b1 || req1_ready !== 1'b1) $display("FAIL midrst_ready got %0b%0b exp 11", req0_ready, req1_ready); else n_pass++;
        n_chk++; if (pending !== 1'b0) $display("FAIL midrst_pending got %0b exp 0", pending); else n_pass++;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        prev_both_low = 0;
        n_w = alog.size();
        idle(5, 5'd11);
        n_chk++; if (alog.size() != n_w) $display("FAIL midrst_stale got %0d exp 0", alog.size() - n_w); else n_pass++;
        n_chk++; if (obs_r0 !== 1'b1 || obs_r1 !== 1'b1) $display("FAIL midrst_after_ready got %0b%0b exp 11", obs_r0, obs_r1); else n_pass++;
    endtask

    task automatic test_same_addr();
        apply_reset();
        wlog.delete();
        step(1, 5'd3, 32'hA, 1, 5'd3, 32'hB, '0);
        idle(4, 5'd3);
        n_chk++; if (wlog.size() != 2) $display("FAIL same_count got %0d exp 2", wlog.size()); else n_pass++;
        if (wlog.size() == 2) begin
            n_chk++; if (wlog[0] !== 32'hA || wlog[1] !== 32'hB) $display("FAIL same_order got %0h,%0h exp a,b", wlog[0], wlog[1]); else n_pass++;
        end
        n_chk++; if (tb_rf[3] !== 32'hB) $display("FAIL same_final got %0h exp b", tb_rf[3]); else n_pass++;
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 1), AW'($urandom_range(0, 7)), $urandom,
                 $urandom_range(0, 1), AW'($urandom_range(0, 7)), $urandom,
                 AW'($urandom_range(0, 7)));
        idle(4, '0);
        for (int r = 1; r < 32; r++) begin
            n_chk++; if (tb_rf[r] !== m_rf[r]) $display("FAIL rand_rf[%0d] got %0h exp %0h", r, tb_rf[r], m_rf[r]); else n_pass++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        for (int r = 0; r < 32; r++) begin tb_rf[r] = '0; m_rf[r] = '0; end
        req0_addr = '0; req1_addr = '0; req0_data = '0; req1_data = '0;
        prev_both_low = 0; both_low_twice = 0;
        model_reset();
        test_reset();
        test_single();
        test_back_to_back();
        test_drop();
        test_pending();
        test_reset_mid();
        test_same_addr();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
